acc_lut_arbiter: RTL

- Shares the single combinational accumulator constant LUT (5-bit key, 8-bit value, enable gated) between NUM_REQ requesters, e.g. decode stage, init/loader, debug port.
- Round-robin arbitration, per-requester valid/ready request handshake, registered one-cycle response pulse.
- Sits between the requesters and the LUT instance. Only this block drives the LUT enable and key.

---
 rtl/acc_lut_pkg.sv | 24 ++
 rtl/acc_lut_arbiter_rr_pick.sv | 30 +++
 rtl/acc_lut_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/acc_lut_pkg.sv
// Shared types and constants for the accumulator constant LUT and its arbiter.
package acc_lut_pkg;

  localparam int unsigned KEY_W     = 5;
  localparam int unsigned VAL_W     = 8;
  localparam int unsigned NUM_CONST = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } arb_state_t;

  // Keys of the defined LUT entries; anything >= NUM_CONST reads back as zero.
  localparam logic [KEY_W-1:0] KEY_MAX  = 5'd0;
  localparam logic [KEY_W-1:0] KEY_63   = 5'd1;
  localparam logic [KEY_W-1:0] KEY_ZERO = 5'd2;
  localparam logic [KEY_W-1:0] KEY_ONE  = 5'd3;
  localparam logic [KEY_W-1:0] KEY_64   = 5'd4;
  localparam logic [KEY_W-1:0] KEY_65   = 5'd5;
  localparam logic [KEY_W-1:0] KEY_66   = 5'd6;
  localparam logic [KEY_W-1:0] KEY_MSB  = 5'd7;

endpackage

// File: rtl/acc_lut_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int unsigned w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/acc_lut_arbiter.sv
// Round-robin arbiter sharing one combinational constant LUT between NUM_REQ requesters.
// Optional out-of-range key flag on rsp_err when ACC_LUT_ARB_KEYCHK_EN is defined.
module acc_lut_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned KEY_W     = acc_lut_pkg::KEY_W,
  parameter int unsigned VAL_W     = acc_lut_pkg::VAL_W,
  parameter int unsigned NUM_CONST = acc_lut_pkg::NUM_CONST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*KEY_W-1:0] req_key,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [VAL_W-1:0]         rsp_value,
  output logic                     rsp_err,
  output logic                     lut_en,
  output logic [KEY_W-1:0]         lut_key,
  input  logic [VAL_W-1:0]         lut_value,
  output logic                     busy
);

  import acc_lut_pkg::*;

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_id_q;
  logic [KEY_W-1:0]     r_key_q;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [VAL_W-1:0]     r_rsp_value;
  logic [NUM_REQ-1:0]   w_win_gnt;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_any;
  logic                 w_accept;
  logic [KEY_W-1:0]     w_keys [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_keys
    assign w_keys[g] = req_key[g*KEY_W +: KEY_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_win_gnt),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

  // Handshake is gated by reset so req_ready reads zero while reset is held.
  assign w_accept = (r_state == IDLE) && w_any && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    lut_en      = 1'b0;
    lut_key     = '0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready   = w_win_gnt;
          w_state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        lut_en      = 1'b1;
        lut_key     = r_key_q;
        w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Held request, rotating pointer and the registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_id_q      <= '0;
      r_key_q     <= '0;
      r_rsp_valid <= '0;
      r_rsp_value <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_key_q  <= w_keys[w_win_idx];
        r_id_q   <= w_win_idx;
        r_rr_ptr <= (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(w_win_idx + 1'b1);
      end
      if (r_state == LOOKUP) begin
        r_rsp_value         <= lut_value;
        r_rsp_valid[r_id_q] <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_value = r_rsp_value;

`ifdef ACC_LUT_ARB_KEYCHK_EN
  logic r_rsp_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_rsp_err <= 1'b0;
    else if (r_state == LOOKUP) r_rsp_err <= (32'(r_key_q) >= NUM_CONST);
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
